// File: rtl/median_pkg.sv
// Shared definitions for the median dataflow chain.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package median_pkg;

  // Default window geometry and token constants.
  localparam int         DEF_BUFF_SIZE  = 1024;
  localparam int         DEF_MEDIAN_POS = DEF_BUFF_SIZE / 2;
  localparam logic [7:0] DEF_PIVOT      = 8'd127;

  // Size/position tokens must be able to hold the value BUFF_SIZE itself.
  function automatic int buff_size_bit(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CTRL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/median_window_buffer.sv
// Window store: DEPTH x 8 RAM, synchronous write, asynchronous read, wrapping pointers.
// Latency: write lands on the clock edge; read data follows rd pointer combinationally.
// Backpressure: none internally; caller advances pointers only on accepted transfers.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset (pointers only)
//   wr_en, wr_dat       : store wr_dat at wr pointer and advance it
//   rd_en, rd_dat       : rd_dat = mem[rd pointer]; rd_en advances the pointer
//   wr_last, rd_last    : pointer currently addresses index DEPTH-1
module median_window_buffer #(
  parameter int  DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_dat,
  input  logic       rd_en,
  output logic [7:0] rd_dat,
  output logic       wr_last,
  output logic       rd_last
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_last  = (wr_ptr_q == AW'(DEPTH - 1));
    rd_last  = (rd_ptr_q == AW'(DEPTH - 1));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_last ? '0 : wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_last ? '0 : rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Contents are not reset: a stale window is unreachable once pointers are zeroed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr_q];

endmodule

// File: rtl/median_first_actor.sv
// Head of the median chain: buffer one window, emit mean + constant tokens, replay pixels.
// Latency: tokens 1 cycle after the last pop; first replayed pixel 1 cycle after CTRL->DRAIN.
// Backpressure: each token waits on its own full flag; replay stalls on out_px_full; pops only in FILL.
//
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   in_px / in_px_rd / in_px_empty    : FWFT pixel source
//   out_px / out_px_wr / out_px_full  : replayed pixels, in arrival order
//   out_pivot*, out_buff_size*, out_median_pos*, out_second_median_value* : one token each per window
module median_first_actor
  import median_pkg::*;
#(
  parameter int         BUFF_SIZE     = DEF_BUFF_SIZE,
  parameter int         BUFF_SIZE_BIT = buff_size_bit(BUFF_SIZE),
  parameter int         MEDIAN_POS    = BUFF_SIZE / 2,
  parameter logic [7:0] DEFAULT_PIVOT = DEF_PIVOT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  output logic                     in_px_rd,
  input  logic                     in_px_empty,
  output logic [7:0]               out_px,
  output logic                     out_px_wr,
  input  logic                     out_px_full,
  output logic [7:0]               out_pivot,
  output logic                     out_pivot_wr,
  input  logic                     out_pivot_full,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic                     out_buff_size_wr,
  input  logic                     out_buff_size_full,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic                     out_median_pos_wr,
  input  logic                     out_median_pos_full,
  output logic [7:0]               out_second_median_value,
  output logic                     out_second_median_value_wr,
  input  logic                     out_second_median_value_full
);

  localparam int LOG_BS = $clog2(BUFF_SIZE);
  // 8-bit pixels times BUFF_SIZE entries: the window sum cannot overflow this width.
  localparam int SUM_W  = 8 + LOG_BS;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, sum_next;
  logic [7:0]       pivot_q, pivot_d;
  // Token bit order: [0] pivot, [1] buff_size, [2] median_pos, [3] second_median_value.
  logic [3:0]       sent_q, sent_d;
  logic [3:0]       tok_full, tok_wr;
  logic             px_pop, px_push;
  logic             wr_last, rd_last;
  logic [7:0]       rd_dat;

  median_window_buffer #(
    .DEPTH (BUFF_SIZE)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (px_pop),
    .wr_dat  (in_px),
    .rd_en   (px_push),
    .rd_dat  (rd_dat),
    .wr_last (wr_last),
    .rd_last (rd_last)
  );

  assign tok_full = {out_second_median_value_full, out_median_pos_full,
                     out_buff_size_full, out_pivot_full};
  assign sum_next = sum_q + SUM_W'(in_px);

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    pivot_d   = pivot_q;
    sent_d    = sent_q;
    in_px_rd  = 1'b0;
    px_pop    = 1'b0;
    px_push   = 1'b0;
    tok_wr    = '0;
    out_px_wr = 1'b0;
    out_px    = 8'd0;
    // Every strobe stays low during the reset cycle.
    if (!reset) begin
      case (state_q)
        FILL: begin
          in_px_rd = 1'b1;
          px_pop   = ~in_px_empty;
          if (px_pop) begin
            sum_d = sum_next;
            if (wr_last) begin
              // Power-of-two window: the upper 8 bits of the sum are the truncated mean.
              pivot_d = sum_next[SUM_W-1:LOG_BS];
              sum_d   = '0;
              state_d = CTRL;
            end
          end
        end
        CTRL: begin
          tok_wr = ~sent_q & ~tok_full;
          sent_d = sent_q | tok_wr;
          // Leave as soon as the last outstanding token goes out, including this cycle's.
          if (&sent_d) begin
            sent_d  = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          out_px    = rd_dat;
          out_px_wr = ~out_px_full;
          px_push   = out_px_wr;
          if (px_push && rd_last) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      sum_q   <= '0;
      pivot_q <= DEFAULT_PIVOT;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      pivot_q <= pivot_d;
      sent_q  <= sent_d;
    end
  end

  assign out_pivot_wr               = tok_wr[0];
  assign out_buff_size_wr           = tok_wr[1];
  assign out_median_pos_wr          = tok_wr[2];
  assign out_second_median_value_wr = tok_wr[3];

  assign out_pivot               = pivot_q;
  assign out_buff_size           = BUFF_SIZE_BIT'(BUFF_SIZE);
  assign out_median_pos          = BUFF_SIZE_BIT'(MEDIAN_POS);
  assign out_second_median_value = DEFAULT_PIVOT;

endmodule

// File: tb/tb_median_first_actor.sv
// Testbench for median_first_actor with a 16-pixel window.
// Reference: a window queue, the mean by plain division, and a replay queue of the same pixels.
// Each cycle the outputs are sampled 1 time unit after the falling edge.
module tb_median_first_actor;

  localparam int BS  = 16;
  localparam int BSB = $clog2(BS) + 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     in_px = 8'd0;
  logic           in_px_rd;
  logic           in_px_empty = 1'b1;
  logic [7:0]     out_px;
  logic           out_px_wr;
  logic           out_px_full = 1'b0;
  logic [7:0]     out_pivot;
  logic           out_pivot_wr;
  logic           out_pivot_full = 1'b0;
  logic [BSB-1:0] out_buff_size;
  logic           out_buff_size_wr;
  logic           out_buff_size_full = 1'b0;
  logic [BSB-1:0] out_median_pos;
  logic           out_median_pos_wr;
  logic           out_median_pos_full = 1'b0;
  logic [7:0]     out_second_median_value;
  logic           out_second_median_value_wr;
  logic           out_second_median_value_full = 1'b0;

  always #5 clock = ~clock;

  median_first_actor #(.BUFF_SIZE(BS)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .in_px                        (in_px),
    .in_px_rd                     (in_px_rd),
    .in_px_empty                  (in_px_empty),
    .out_px                       (out_px),
    .out_px_wr                    (out_px_wr),
    .out_px_full                  (out_px_full),
    .out_pivot                    (out_pivot),
    .out_pivot_wr                 (out_pivot_wr),
    .out_pivot_full               (out_pivot_full),
    .out_buff_size                (out_buff_size),
    .out_buff_size_wr             (out_buff_size_wr),
    .out_buff_size_full           (out_buff_size_full),
    .out_median_pos               (out_median_pos),
    .out_median_pos_wr            (out_median_pos_wr),
    .out_median_pos_full          (out_median_pos_full),
    .out_second_median_value      (out_second_median_value),
    .out_second_median_value_wr   (out_second_median_value_wr),
    .out_second_median_value_full (out_second_median_value_full)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] src_q[$];
  logic [7:0] win_q[$];
  logic [7:0] drain_q[$];
  bit         busy = 1'b0;
  bit         tok_done = 1'b0;
  bit         drain_active = 1'b0;
  int         tok_seen[4];
  int         tok_cyc[4];
  logic [7:0] exp_pivot = 8'd127;
  logic [7:0] exp_pivot_reg = 8'd127;
  logic [7:0] last_pivot_tok = 8'd0;
  int         cyc = 0;
  int         last_pop_cyc = 0;
  int         first_px_cyc = 0;
  int         last_px_cyc = 0;
  int         pop_total = 0;

  // Stimulus knobs.
  int gap_pct = 0;
  int pivot_hold = 0;
  bit px_toggle = 1'b0;
  bit rand_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit coin30();
    return rand_full && ($urandom_range(99) < 30);
  endfunction

  task automatic observe();
    logic [3:0] wr;
    logic [3:0] full;
    int s;
    wr   = {out_second_median_value_wr, out_median_pos_wr, out_buff_size_wr, out_pivot_wr};
    full = {out_second_median_value_full, out_median_pos_full, out_buff_size_full, out_pivot_full};
    if (reset) begin
      chk("rst_rd", in_px_rd, 0);
      chk("rst_wr", {wr, out_px_wr}, 0);
      win_q.delete();
      drain_q.delete();
      busy = 0;
      tok_done = 0;
      drain_active = 0;
      exp_pivot_reg = 8'd127;
      for (int i = 0; i < 4; i++) tok_seen[i] = 0;
    end else begin
      chk("pivot_out", out_pivot, exp_pivot_reg);
      chk("rd_strobe", in_px_rd, busy ? 0 : 1);
      if (!drain_active) chk("px_idle", out_px, 0);
      for (int i = 0; i < 4; i++) begin
        if (wr[i]) begin
          chk("tok_full", full[i], 0);
          chk("tok_busy", busy, 1);
          chk("tok_dup", tok_seen[i], 0);
          tok_seen[i]++;
          tok_cyc[i] = cyc;
          case (i)
            0: begin chk("tok_pivot", out_pivot, exp_pivot); last_pivot_tok = out_pivot; end
            1: chk("tok_bsize", out_buff_size, BS);
            2: chk("tok_mpos", out_median_pos, BS / 2);
            default: chk("tok_second", out_second_median_value, 127);
          endcase
        end
      end
      if (out_px_wr) begin
        chk("px_full", out_px_full, 0);
        chk("px_early", drain_active, 1);
        chk("px_avail", drain_q.size() > 0, 1);
        if (drain_q.size() > 0) begin
          if (drain_q.size() == BS) first_px_cyc = cyc;
          chk("px_val", out_px, drain_q.pop_front());
          if (drain_q.size() == 0) begin
            last_px_cyc = cyc;
            busy = 0;
            tok_done = 0;
            for (int i = 0; i < 4; i++) tok_seen[i] = 0;
          end
        end
      end
      if (in_px_rd && !in_px_empty) begin
        pop_total++;
        win_q.push_back(in_px);
        void'(src_q.pop_front());
        if (win_q.size() == BS) begin
          s = 0;
          foreach (win_q[k]) s += int'(win_q[k]);
          exp_pivot     = 8'(s / BS);
          exp_pivot_reg = exp_pivot;
          drain_q       = win_q;
          win_q.delete();
          busy          = 1;
          last_pop_cyc  = cyc;
          for (int i = 0; i < 4; i++) tok_seen[i] = 0;
        end
      end
      if (busy && tok_seen[0] == 1 && tok_seen[1] == 1 && tok_seen[2] == 1 && tok_seen[3] == 1)
        tok_done = 1;
      drain_active = tok_done;
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (src_q.size() == 0 || $urandom_range(99) < gap_pct) begin
      in_px_empty = 1'b1;
      in_px       = 8'($urandom);
    end else begin
      in_px_empty = 1'b0;
      in_px       = src_q[0];
    end
    out_px_full                  = px_toggle ? cyc[0] : coin30();
    out_pivot_full               = (pivot_hold > 0) || coin30();
    out_buff_size_full           = coin30();
    out_median_pos_full          = coin30();
    out_second_median_value_full = coin30();
    if (pivot_hold > 0) pivot_hold--;
    #1;
    observe();
    cyc++;
  endtask

  task automatic run_window(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk("window_done", (src_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    int n;
    int p0;
    // Reset.
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_pivot", out_pivot, 127);
    chk("rst_fill_rd", in_px_rd, 1);
    chk("const_bsize", out_buff_size, 16);
    chk("const_mpos", out_median_pos, 8);
    chk("const_second", out_second_median_value, 127);

    // 1: flat window, no backpressure, exact latencies.
    for (int i = 0; i < BS; i++) src_q.push_back(8'd7);
    run_window(200);
    chk("t1_pivot", last_pivot_tok, 7);
    for (int i = 0; i < 4; i++) chk("t1_tok_lat", tok_cyc[i], last_pop_cyc + 1);
    chk("t1_px_lat", first_px_cyc, last_pop_cyc + 2);
    chk("t1_px_span", last_px_cyc - first_px_cyc, BS - 1);

    // 2: ramp with random empty gaps.
    gap_pct = 40;
    p0 = pop_total;
    for (int i = 0; i < BS; i++) src_q.push_back(8'(i));
    run_window(2000);
    chk("t2_pivot", last_pivot_tok, 7);
    chk("t2_pops", pop_total - p0, BS);
    gap_pct = 0;

    // 3: saturated window, then zeros (sum must have been cleared).
    for (int i = 0; i < BS; i++) src_q.push_back(8'd255);
    run_window(200);
    chk("t3_pivot_max", last_pivot_tok, 255);
    for (int i = 0; i < BS; i++) src_q.push_back(8'd0);
    run_window(200);
    chk("t3_pivot_zero", last_pivot_tok, 0);

    // 4: pivot FIFO full for 20 CTRL cycles.
    for (int i = 0; i < BS; i++) src_q.push_back(8'($urandom));
    n = 0;
    while (!busy && n < 100) begin step(); n++; end
    chk("t4_filled", busy, 1);
    pivot_hold = 20;
    run_window(500);
    chk("t4_pivot_lat", tok_cyc[0], last_pop_cyc + 21);
    for (int i = 1; i < 4; i++) chk("t4_other_lat", tok_cyc[i], last_pop_cyc + 1);
    chk("t4_px_lat", first_px_cyc, last_pop_cyc + 22);

    // 5: replay with out_px_full toggling every cycle.
    px_toggle = 1'b1;
    for (int i = 0; i < BS; i++) src_q.push_back(8'($urandom));
    run_window(500);
    px_toggle = 1'b0;
    chk("t5_px_span", last_px_cyc - first_px_cyc, 2 * (BS - 1));

    // 6: reset after 9 pops discards the partial window.
    for (int i = 0; i < 9; i++) src_q.push_back(8'(200 + i));
    n = 0;
    while (win_q.size() < 9 && n < 100) begin step(); n++; end
    chk("t6_partial", win_q.size(), 9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    src_q.delete();
    for (int i = 1; i <= BS; i++) src_q.push_back(8'(i));
    run_window(200);
    chk("t6_pivot", last_pivot_tok, 8);

    // Random pixels, gaps and backpressure on every output.
    rand_full = 1'b1;
    gap_pct   = 30;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < BS; i++) src_q.push_back(8'($urandom));
      run_window(3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/median_first_actor.md
Name: median_first_actor

Overview:
Head stage of the median dataflow chain, placed directly upstream of the first median_middle_actor.
- Collects one window of BUFF_SIZE pixels from the pixel source FIFO into an internal buffer and accumulates their sum.
- Emits one token each of pivot (window mean), buff_size, median_pos and second_median_value.
- Then replays the buffered pixels in arrival order on out_px, which is the px input of the first middle actor.

Parameters:
BUFF_SIZE, 11'd1024, pixels per window; power of two, >= 2.
BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size/position tokens.
MEDIAN_POS, BUFF_SIZE/2, median position token value.
DEFAULT_PIVOT, 8'd127, reset value of out_pivot and constant out_second_median_value.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
in_px  in  8  source pixel; valid whenever in_px_empty=0 (first-word-fall-through FIFO).
in_px_rd  out  1  pop strobe; a pixel is consumed in a cycle where in_px_rd=1 and in_px_empty=0.
in_px_empty  in  1  source FIFO empty.
out_px  out  8  replayed pixel.
out_px_wr  out  1  push strobe; asserted only when out_px_full=0.
out_px_full  in  1  downstream px FIFO full.
out_pivot  out  8  window mean.
out_pivot_wr  out  1  pivot push strobe.
out_pivot_full  in  1  pivot FIFO full.
out_buff_size  out  BUFF_SIZE_BIT  constant BUFF_SIZE.
out_buff_size_wr  out  1  buff_size push strobe.
out_buff_size_full  in  1  buff_size FIFO full.
out_median_pos  out  BUFF_SIZE_BIT  constant MEDIAN_POS.
out_median_pos_wr  out  1  median_pos push strobe.
out_median_pos_full  in  1  median_pos FIFO full.
out_second_median_value  out  8  constant DEFAULT_PIVOT.
out_second_median_value_wr  out  1  push strobe.
out_second_median_value_full  in  1  FIFO full.

Behaviour:
- States: FILL -> CTRL -> DRAIN -> FILL. Reset (synchronous, active-high, takes priority over every other event) gives:
  - state=FILL, wr_ptr=0, rd_ptr=0, sum=0;
  - the four sent flags cleared, pivot_reg=DEFAULT_PIVOT;
  - all *_wr=0, in_px_rd=0 during the reset cycle.
- FILL:
  - in_px_rd=1.
  - On each cycle with in_px_empty=0: mem[wr_ptr]<=in_px, wr_ptr++, sum<=sum+in_px.
  - Empty cycles stall with no state change.
  - On the pop that writes index BUFF_SIZE-1:
    - pivot_reg <= (sum+in_px) >> $clog2(BUFF_SIZE), i.e. truncating mean;
    - sum<=0, wr_ptr<=0, next state CTRL.
  - sum width is 8+$clog2(BUFF_SIZE) bits; it never overflows.
- CTRL:
  - in_px_rd=0.
  - Each control output X: X_wr = ~X_sent & ~X_full. X_sent is set on the cycle X_wr=1.
  - The four tokens are independent; any subset may be written in the same cycle.
  - Exactly one token per output per window, never duplicated.
  - When all four are sent (including flags set this cycle), next state DRAIN and flags clear.
- DRAIN:
  - out_px = mem[rd_ptr], combinational (asynchronous-read buffer).
  - out_px_wr = ~out_px_full. Each write does rd_ptr++.
  - The write of index BUFF_SIZE-1 does rd_ptr<=0, next state FILL.
  - out_px_full stalls with no pointer change; pixel order is preserved exactly.
- Outside DRAIN, out_px=8'd0.
- out_pivot=pivot_reg at all times. out_buff_size, out_median_pos and out_second_median_value are constants.
- Latency:
  - first control write 1 cycle after the last pixel pop;
  - first out_px write 1 cycle after the CTRL->DRAIN transition, when nothing is full.
  - Minimum window period 2*BUFF_SIZE+1 cycles.
- Pixel reads never overlap drain; the next window is not popped until drain completes.
- Reset mid-window discards buffered pixels and partial tokens. Tokens already written stay in the downstream FIFOs; clearing those is system reset's responsibility.

Decomposition:
- Shared package median_pkg holds:
  - default constants (BUFF_SIZE, MEDIAN_POS, DEFAULT_PIVOT);
  - the BUFF_SIZE_BIT function;
  - the state enum FILL/CTRL/DRAIN.
- One sub-module, median_window_buffer: BUFF_SIZE x 8 RAM with synchronous write and asynchronous read, plus wr/rd pointer counters and wrap detection. FSM, accumulator and token logic stay in the top.

Test Plan:
1. BUFF_SIZE=16, 16 pixels of 7, no backpressure -> one token each: pivot=7, buff_size=16, median_pos=8, second=127. Then out_px = 16x7 on consecutive cycles.
2. Ramp 0..15 with random in_px_empty gaps -> sum=120, pivot=7. out_px = 0..15 in order; only 16 pops occur.
3. Pixels 255 x16 -> pivot=255 (no overflow). Next window 0 x16 -> pivot=0 (sum was cleared).
4. out_pivot_full held high 20 cycles during CTRL, others free -> other three written at once. Pivot is written once, 1 cycle after full deasserts. DRAIN is not entered earlier.
5. out_px_full toggled every other cycle during DRAIN -> no write while full, no duplicated or dropped pixel, and in_px_rd stays 0 until the 16th write.
6. Reset asserted after 9 pops in FILL, then 16 new pixels 1..16 -> pivot = 136>>4 = 8, and out_px = 1..16. The 9 earlier pixels never appear.
